// File: rtl/jpeg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_scan_ctrl
// Purpose  : Routes JPEG bytes to the header parser or the entropy reader and
//            resolves FF-prefixed sequences (stuffing, fill, RSTn, EOI).
// Revision : 1.0
// ============================================================================
module jpeg_scan_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_scan,
    input  logic [15:0] restart_interval,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  hdr_byte,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [7:0]  ent_byte,
    output logic        ent_valid,
    input  logic        ent_ready,
    input  logic        mcu_done,
    output logic        resync,
    output logic        eoi,
    output logic        marker_err,
    output logic        scan_active
);

    localparam logic [1:0] c_ST_HDR     = 2'd0;
    localparam logic [1:0] c_ST_SCAN    = 2'd1;
    localparam logic [1:0] c_ST_SCAN_FF = 2'd2;
    localparam logic [1:0] c_ST_EMIT_00 = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [7:0]  r_ent_byte;
    logic        r_ent_valid;
    logic        r_resync;
    logic        r_eoi;
    logic        r_marker_err;
    logic [15:0] r_interval;
    logic [15:0] r_mcu_cnt;
    logic [2:0]  r_rst_idx;

    logic        w_in_fire;
    logic        w_ent_fire;
    logic        w_start_acc;
    logic        w_ent_load;
    logic [7:0]  w_ent_load_byte;
    logic        w_rst_hit;
    logic        w_rst_bad;
    logic        w_eoi_hit;
    logic        w_err_hit;

    assign w_in_fire   = in_valid & in_ready;
    assign w_ent_fire  = r_ent_valid & ent_ready;
    assign w_start_acc = (r_state == c_ST_HDR) & start_scan;
    assign w_rst_bad   = (r_interval == 16'h0000) | (r_mcu_cnt != r_interval) |
                         (in_byte[2:0] != r_rst_idx);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_HDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-byte decode
    always_comb begin
        w_state_next    = r_state;
        w_ent_load      = 1'b0;
        w_ent_load_byte = 8'h00;
        w_rst_hit       = 1'b0;
        w_eoi_hit       = 1'b0;
        w_err_hit       = 1'b0;
        case (r_state)
            c_ST_HDR: begin
                if (start_scan) w_state_next = c_ST_SCAN;
            end
            c_ST_SCAN: begin
                if (w_in_fire) begin
                    if (in_byte == 8'hFF) begin
                        w_state_next = c_ST_SCAN_FF;
                    end else begin
                        w_ent_load      = 1'b1;
                        w_ent_load_byte = in_byte;
                    end
                end
            end
            c_ST_SCAN_FF: begin
                if (w_in_fire) begin
                    if (in_byte == 8'h00) begin
                        // Stuffed pair goes to the reader intact: FF now, 00 next.
                        w_ent_load      = 1'b1;
                        w_ent_load_byte = 8'hFF;
                        w_state_next    = c_ST_EMIT_00;
                    end else if (in_byte == 8'hFF) begin
                        w_state_next = c_ST_SCAN_FF;
                    end else if (in_byte[7:3] == 5'b11010) begin
                        w_rst_hit    = 1'b1;
                        w_state_next = c_ST_SCAN;
                    end else if (in_byte == 8'hD9) begin
                        w_eoi_hit    = 1'b1;
                        w_state_next = c_ST_HDR;
                    end else begin
                        w_err_hit    = 1'b1;
                        w_state_next = c_ST_HDR;
                    end
                end
            end
            c_ST_EMIT_00: begin
                if (!r_ent_valid || ent_ready) begin
                    w_ent_load      = 1'b1;
                    w_ent_load_byte = 8'h00;
                    w_state_next    = c_ST_SCAN;
                end
            end
            default: w_state_next = c_ST_HDR;
        endcase
    end

    // Output decode
    always_comb begin
        hdr_byte  = in_byte;
        hdr_valid = 1'b0;
        in_ready  = 1'b0;
        case (r_state)
            c_ST_HDR: begin
                hdr_valid = in_valid;
                in_ready  = hdr_ready & ~start_scan;
            end
            c_ST_SCAN:    in_ready = ~r_ent_valid | ent_ready;
            // Reader must drain before a marker is acted upon.
            c_ST_SCAN_FF: in_ready = ~r_ent_valid;
            default:      in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ent_byte   <= 8'h00;
            r_ent_valid  <= 1'b0;
            r_resync     <= 1'b0;
            r_eoi        <= 1'b0;
            r_marker_err <= 1'b0;
            r_interval   <= 16'h0000;
            r_mcu_cnt    <= 16'h0000;
            r_rst_idx    <= 3'd0;
        end else begin
            if (w_ent_load) begin
                r_ent_byte  <= w_ent_load_byte;
                r_ent_valid <= 1'b1;
            end else if (w_ent_fire) begin
                r_ent_valid <= 1'b0;
            end

            r_resync <= w_rst_hit;
            r_eoi    <= w_eoi_hit;

            if (w_start_acc) begin
                r_marker_err <= 1'b0;
                r_interval   <= restart_interval;
                r_rst_idx    <= 3'd0;
            end else begin
                if (w_err_hit || (w_rst_hit && w_rst_bad)) r_marker_err <= 1'b1;
                if (w_rst_hit) r_rst_idx <= in_byte[2:0] + 3'd1;
            end

            if (w_start_acc || w_rst_hit) begin
                r_mcu_cnt <= 16'h0000;
            end else if (mcu_done && (r_state != c_ST_HDR) && (r_mcu_cnt != 16'hFFFF)) begin
                r_mcu_cnt <= r_mcu_cnt + 16'h0001;
            end
        end
    end

    assign ent_byte    = r_ent_byte;
    assign ent_valid   = r_ent_valid;
    assign resync      = r_resync;
    assign eoi         = r_eoi;
    assign marker_err  = r_marker_err;
    assign scan_active = (r_state != c_ST_HDR);

endmodule
`default_nettype wire

// File: tb/tb_jpeg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_scan_ctrl
// Purpose  : Directed scoreboard bench for jpeg_scan_ctrl.
// Revision : 1.0
// ============================================================================
module tb_jpeg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_scan;
    logic [15:0] restart_interval;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  hdr_byte;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [7:0]  ent_byte;
    logic        ent_valid;
    logic        ent_ready;
    logic        mcu_done;
    logic        resync;
    logic        eoi;
    logic        marker_err;
    logic        scan_active;

    int tests;
    int fails;
    int stalls;
    int resync_cnt;
    int eoi_cnt;
    logic [7:0] hdr_q[$];
    logic [7:0] ent_q[$];

    jpeg_scan_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_scan       (start_scan),
        .restart_interval (restart_interval),
        .in_byte          (in_byte),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .hdr_byte         (hdr_byte),
        .hdr_valid        (hdr_valid),
        .hdr_ready        (hdr_ready),
        .ent_byte         (ent_byte),
        .ent_valid        (ent_valid),
        .ent_ready        (ent_ready),
        .mcu_done         (mcu_done),
        .resync           (resync),
        .eoi              (eoi),
        .marker_err       (marker_err),
        .scan_active      (scan_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: all inputs change at negedge, so +2 sees settled handshakes.
    logic [7:0] prev_byte;
    logic       prev_hold;
    initial prev_hold = 1'b0;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("ent_hold_valid", {31'b0, ent_valid}, 32'd1);
                check("ent_hold_byte", {24'b0, ent_byte}, {24'b0, prev_byte});
            end
            if (ent_valid && ent_ready) begin
                if (ent_q.size() == 0) begin
                    check("ent_unexpected", {24'b0, ent_byte}, 32'hFFFF_FFFF);
                end else begin
                    check("ent_data", {24'b0, ent_byte}, {24'b0, ent_q.pop_front()});
                end
            end
            if (hdr_valid && hdr_ready) begin
                if (hdr_q.size() == 0) begin
                    check("hdr_unexpected", {24'b0, hdr_byte}, 32'hFFFF_FFFF);
                end else begin
                    check("hdr_data", {24'b0, hdr_byte}, {24'b0, hdr_q.pop_front()});
                end
            end
            if (resync) begin
                resync_cnt++;
                check("resync_ent_valid", {31'b0, ent_valid}, 32'd0);
            end
            if (eoi) begin
                eoi_cnt++;
                check("eoi_scan_active", {31'b0, scan_active}, 32'd0);
                check("eoi_ent_valid", {31'b0, ent_valid}, 32'd0);
            end
            prev_hold = ent_valid && !ent_ready;
            prev_byte = ent_byte;
        end
    end

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            #1;
            if (in_ready) begin
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            stalls++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("send_timeout", {24'b0, b}, 32'hFFFF_FFFF);
    endtask

    task automatic begin_scan(input logic [15:0] ri);
        restart_interval = ri;
        start_scan = 1'b1;
        @(negedge clk);
        start_scan = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_mcu(input int n);
        for (int i = 0; i < n; i++) begin
            mcu_done = 1'b1;
            @(negedge clk);
            mcu_done = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tests = 0; fails = 0; stalls = 0; resync_cnt = 0; eoi_cnt = 0;
        rst_n = 1'b0; start_scan = 1'b0; restart_interval = 16'h0;
        in_byte = 8'h00; in_valid = 1'b0; hdr_ready = 1'b0;
        ent_ready = 1'b0; mcu_done = 1'b0;

        // Reset state, with hdr port mirroring the input side.
        idle(3);
        in_valid = 1'b1;
        in_byte  = 8'h5A;
        #2;
        check("rst_ent_valid", {31'b0, ent_valid}, 32'd0);
        check("rst_resync", {31'b0, resync}, 32'd0);
        check("rst_eoi", {31'b0, eoi}, 32'd0);
        check("rst_marker_err", {31'b0, marker_err}, 32'd0);
        check("rst_scan_active", {31'b0, scan_active}, 32'd0);
        check("rst_hdr_valid", {31'b0, hdr_valid}, 32'd1);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);

        // HDR passthrough with toggling hdr_ready.
        hdr_q.push_back(8'hFF); hdr_q.push_back(8'hD8);
        hdr_q.push_back(8'hFF); hdr_q.push_back(8'hDB);
        fork
            begin
                send(8'hFF); send(8'hD8); send(8'hFF); send(8'hDB);
            end
            begin
                repeat (14) begin
                    hdr_ready = ~hdr_ready;
                    @(negedge clk);
                end
            end
        join
        hdr_ready = 1'b1;
        idle(2);
        check("hdr_q_drained", hdr_q.size(), 32'd0);

        // Scan data with a stuffed pair.
        ent_ready = 1'b1;
        begin_scan(16'd0);
        check("scan_active_on", {31'b0, scan_active}, 32'd1);
        ent_q.push_back(8'h12); ent_q.push_back(8'h34); ent_q.push_back(8'hFF);
        ent_q.push_back(8'h00); ent_q.push_back(8'h56);
        stalls = 0;
        send(8'h12); send(8'h34); send(8'hFF); send(8'h00); send(8'h56);
        check("ff00_stalls", stalls, 32'd1);
        idle(3);
        check("ent_q_drained_1", ent_q.size(), 32'd0);

        // Fill bytes under backpressure, then EOI.
        ent_ready = 1'b0;
        ent_q.push_back(8'h7A);
        send(8'h7A);
        fork
            begin
                send(8'hFF); send(8'hFF); send(8'hFF); send(8'hD9);
                #2;
                check("eoi_pulse_time", {31'b0, eoi}, 32'd1);
            end
            begin
                repeat (5) @(negedge clk);
                ent_ready = 1'b1;
            end
        join
        @(negedge clk);
        #2;
        check("eoi_one_cycle", {31'b0, eoi}, 32'd0);
        check("eoi_back_to_hdr", {31'b0, scan_active}, 32'd0);
        idle(2);
        check("eoi_count", eoi_cnt, 32'd1);
        check("ent_q_drained_2", ent_q.size(), 32'd0);

        // Restart markers in sequence, counts matching.
        begin_scan(16'd2);
        pulse_mcu(2);
        send(8'hFF); send(8'hD0);
        #2;
        check("resync_time", {31'b0, resync}, 32'd1);
        @(negedge clk);
        ent_q.push_back(8'h9C);
        send(8'h9C);
        pulse_mcu(2);
        send(8'hFF); send(8'hD1);
        idle(2);
        check("resync_count_ok", resync_cnt, 32'd2);
        check("restart_ok_err", {31'b0, marker_err}, 32'd0);
        send(8'hFF); send(8'hD9);
        idle(2);

        // Restart errors: short interval, then wrong index.
        begin_scan(16'd2);
        pulse_mcu(1);
        send(8'hFF); send(8'hD0);
        idle(2);
        check("resync_count_err", resync_cnt, 32'd3);
        check("short_interval_err", {31'b0, marker_err}, 32'd1);
        pulse_mcu(2);
        send(8'hFF); send(8'hD5);
        idle(2);
        check("resync_count_err2", resync_cnt, 32'd4);
        check("bad_index_err", {31'b0, marker_err}, 32'd1);
        send(8'hFF); send(8'hD9);
        idle(2);
        begin_scan(16'd0);
        check("err_cleared", {31'b0, marker_err}, 32'd0);

        // Unknown marker aborts the scan.
        send(8'hFF); send(8'hC4);
        idle(1);
        check("bad_marker_err", {31'b0, marker_err}, 32'd1);
        check("bad_marker_hdr", {31'b0, scan_active}, 32'd0);
        check("eoi_count_2", eoi_cnt, 32'd3);

        // Reset while the ent register holds data.
        begin_scan(16'd0);
        ent_ready = 1'b0;
        ent_q.push_back(8'h12);
        send(8'h12);
        #2;
        check("pre_reset_valid", {31'b0, ent_valid}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        check("mid_rst_ent_valid", {31'b0, ent_valid}, 32'd0);
        check("mid_rst_scan_active", {31'b0, scan_active}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        void'(ent_q.pop_front());
        hdr_q.push_back(8'hAB);
        send(8'hAB);
        idle(2);
        check("post_rst_hdr_drained", hdr_q.size(), 32'd0);
        check("final_ent_q_empty", ent_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/jpeg_scan_ctrl.md
# jpeg_scan_ctrl

Byte-stream controller between the JPEG input byte source and the entropy path. Bytes go to the header parser outside a scan and to `jpeg_bitstream_reader` inside a scan. Within a scan the block handles FF-prefixed sequences: it keeps stuffed FF 00 pairs intact for the reader, drops fill bytes, strips RSTn and EOI markers, and checks the restart interval against MCU completions from the decoder. It sends one-cycle resync and end-of-image pulses to the decoder.

## Interface
Parameters:
- none. All widths are fixed by JPEG: byte 8, restart interval 16.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `start_scan`  in  1  pulse from header parser once the SOS header has been consumed.
- `restart_interval`  in  16  MCUs per restart interval; 0 = restarts disabled; sampled when `start_scan` is accepted.
- `in_byte` / `in_valid` / `in_ready`  in/in/out  8/1/1  input byte stream.
- `hdr_byte` / `hdr_valid` / `hdr_ready`  out/out/in  8/1/1  header-parser byte port.
- `ent_byte` / `ent_valid` / `ent_ready`  out/out/in  8/1/1  connects to the reader's `byte_in` / `byte_valid` / `byte_ready`.
- `mcu_done`  in  1  decoder pulse, one per completed MCU.
- `resync`  out  1  one-cycle pulse after an RSTn marker; the decoder clears DC predictors and discards residual bits.
- `eoi`  out  1  one-cycle pulse after FF D9.
- `marker_err`  out  1  sticky error flag; cleared on an accepted `start_scan`.
- `scan_active`  out  1  high in every SCAN-family state.

## Operation
- States: HDR, SCAN, SCAN_FF, EMIT_00.
- HDR (reset state):
  - `hdr_byte`=`in_byte`, `hdr_valid`=`in_valid`, `in_ready`=`hdr_ready`, all combinational.
  - `ent_valid`=0.
  - `start_scan` → SCAN. Latch `restart_interval`, clear `mcu_cnt`, set `rst_idx`=0, clear `marker_err`.
  - While `start_scan` is high, `in_ready`=0.
- SCAN:
  - `hdr_valid`=0.
  - `in_ready` = !`ent_valid` | `ent_ready`.
  - An accepted non-FF byte loads the ent output register.
  - An accepted FF is consumed without loading and the state moves to SCAN_FF.
- SCAN_FF: `in_ready` = !`ent_valid`, so every earlier byte has been taken by the reader before a marker is decided. On the accepted byte:
  - 00 → load FF into the ent register, go to EMIT_00. Stuffing is removed by the reader, not here.
  - FF → fill byte; discard it and stay in SCAN_FF.
  - D0–D7 → go to SCAN and pulse `resync`. Set `marker_err` if the restart interval is 0, or `mcu_cnt` ≠ interval, or the byte's low 3 bits ≠ `rst_idx`. In every case clear `mcu_cnt` and set `rst_idx` = (received low 3 bits + 1) mod 8.
  - D9 → pulse `eoi`, go to HDR.
  - Any other byte → set `marker_err`, discard the byte, go to HDR.
- EMIT_00:
  - `in_ready`=0.
  - When the ent register is free (empty, or handshaking this cycle), load 00 and go to SCAN.
- `mcu_cnt` (16 bit):
  - Increments on `mcu_done` in SCAN-family states and saturates at FFFFh.
  - `mcu_done` in HDR is ignored.
  - If `mcu_done` coincides with an RST acceptance, the clear wins.
- `start_scan` outside HDR is ignored.
- Reset at any point: return to HDR and drop the ent register contents.

## Timing
- Reset values:
  - `ent_valid`=0, `resync`=0, `eoi`=0, `marker_err`=0, `scan_active`=0.
  - `hdr_valid` mirrors `in_valid`; `in_ready` mirrors `hdr_ready`.
- HDR path has zero latency (combinational).
- SCAN path: `ent_valid` rises one cycle after the input handshake. Full throughput of 1 byte/cycle while `ent_ready` is held high.
- FF 00 costs 2 input cycles and produces 2 output bytes. The input stalls 1 cycle in EMIT_00.
- `resync` / `eoi` assert in the cycle after the marker-byte handshake; `ent_valid`=0 at that point.
- `scan_active` falls in the same cycle that `eoi` is high.
- `ent_byte` holds stable while `ent_valid` & !`ent_ready`.

## Test plan
- HDR passthrough: FF D8 FF DB with `hdr_ready` toggling → identical bytes on the hdr port; `ent_valid` never rises.
- Scan data: `start_scan`, then 12 34 FF 00 56 with `ent_ready`=1 → ent sees 12 34 FF 00 56 in order; exactly one input stall cycle.
- Fill bytes and backpressure: 7A FF FF FF D9, with `ent_ready` low for 5 cycles after 7A → 7A held stable until accepted, no FF forwarded, `eoi` pulses once after D9 is accepted, state HDR.
- Restart OK: interval 2, two `mcu_done` pulses, then FF D0, later two more pulses and FF D1 → two `resync` pulses, `marker_err`=0.
- Restart errors: interval 2, one `mcu_done` then FF D0 → `resync` pulses and `marker_err`=1. Next FF D5 after 2 MCUs → `marker_err` stays 1. A following `start_scan` clears it.
- Reset mid-scan: `rst_n` low while the ent register holds 12 → next cycle `ent_valid`=0, `scan_active`=0, HDR passthrough active.
